// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: forwarding selects, load-use/interlock stalls, branch flushes
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              br_taken,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exm,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ex_entry_t;

    // Source fields and mem_read retire at EX; later stages only need the write-back identity.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
    } wr_entry_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STALL = 2'b01,
        S_FLUSH = 2'b10
    } state_t;

    ex_entry_t ex_q;
    wr_entry_t mem_q, wb_q;
    state_t    state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic [REG_AW-1:0] src_rs, src_rt;
    logic ex_hit, mem_hit, load_use, interlock, hazard;
    logic do_stall, do_flush;
    ex_entry_t id_entry;
    wr_entry_t ex_wr;

    // Unused sources are folded to r0 so they can never match a producer.
    assign src_rs = id_use_rs ? id_rs : '0;
    assign src_rt = id_use_rt ? id_rt : '0;

    assign id_entry = '{valid: id_valid, dst: id_dst, reg_write: id_reg_write,
                        mem_read: id_mem_read, rs: src_rs, rt: src_rt};
    assign ex_wr    = '{valid: ex_q.valid, dst: ex_q.dst, reg_write: ex_q.reg_write};

    function automatic logic writes(input wr_entry_t e, input logic [REG_AW-1:0] r);
        return e.valid && e.reg_write && (e.dst != '0) && (e.dst == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r);
        if (FWD_EN == 0 || !ex_q.valid) return 2'b00;
        if (writes(mem_q, r))           return 2'b01;
        if (writes(wb_q, r))            return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        ex_hit    = writes(ex_wr, src_rs) || writes(ex_wr, src_rt);
        mem_hit   = writes(mem_q, src_rs) || writes(mem_q, src_rt);
        load_use  = (FWD_EN != 0) && id_valid && ex_q.mem_read && ex_hit;
        interlock = (FWD_EN == 0) && id_valid && (ex_hit || mem_hit);
        hazard    = load_use || interlock;
    end

    assign fwd_a = fwd_sel(ex_q.rs);
    assign fwd_b = fwd_sel(ex_q.rt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_RUN;
        if (br_taken) begin
            state_d = S_FLUSH;
        end else if (hazard) begin
            state_d = S_STALL;
        end
    end

    // Outputs are gated by reset and enable so nothing leaks while the pipe is frozen.
    always_comb begin
        do_flush    = rst && enable && br_taken;
        do_stall    = rst && enable && hazard && !br_taken;
        stall_pc    = do_stall;
        stall_ifid  = do_stall;
        bubble_idex = do_stall;
        flush_ifid  = do_flush;
        flush_idex  = do_flush;
        flush_exm   = do_flush;
        state       = state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (enable) begin
            ex_q  <= (hazard || br_taken) ? '0 : id_entry;
            mem_q <= br_taken ? '0 : ex_wr;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (enable) begin
            if (br_taken && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (hazard && !br_taken && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
